eth_rx_frame_queue: RTL and testbench
=====================================

# eth_rx_frame_queue

Parametrised multi-slot receive frame buffer that sits between the Ethernet RX FSM byte stream and the external consumer, replacing the single flat RX memory with a ring of NUM_SLOTS frame slots. Good frames are committed with their length into an in-order descriptor queue; errored, truncated, aborted or overflowing frames are discarded without consuming a slot. The consumer reads the head frame by byte offset and releases it explicitly.

## Interface
- DATA_W, 8: byte lane width.
- NUM_SLOTS, 4: frame slots; power of two, ≥2.
- SLOT_ADDR_W, 11: log2 bytes per slot (2048).
- LEN_W, 16: frame length width; must be ≥ SLOT_ADDR_W+1.
- CNT_W, 16: drop counter width.

- i_main_clk  in  1  single clock, 125 MHz.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_wr_valid  in  1  byte strobe from RX FSM.
- i_wr_data  in  DATA_W  byte, qualified by i_wr_valid.
- i_wr_sof  in  1  first byte of frame; qualified by i_wr_valid.
- i_wr_eof  in  1  last byte of frame; qualified by i_wr_valid.
- i_wr_err  in  1  frame bad (FCS/PHY error); sampled on eof beat.
- o_rd_frame_avail  out  1  head descriptor valid.
- o_rd_slot  out  log2(NUM_SLOTS)  head slot index.
- o_rd_frame_len  out  LEN_W  head frame length in bytes.
- i_rd_addr  in  SLOT_ADDR_W  byte offset within head slot.
- o_rd_data  out  DATA_W  byte at i_rd_addr, one-cycle latency.
- i_rd_release  in  1  pop head frame, free slot.
- o_frames_queued  out  log2(NUM_SLOTS+1)  committed frames held.
- o_drop_count  out  CNT_W  saturating dropped-frame counter.
- o_drop  out  1  one-cycle pulse per dropped frame.
- o_busy  out  1  write FSM not IDLE.

## Operation
- Write FSM states: IDLE, RECV, DISCARD.
- IDLE: valid&sof with o_frames_queued<NUM_SLOTS → write byte at offset 0 of wr_slot, RECV; if full → DISCARD, drop. Valid without sof ignored.
- sof&eof same beat: 1-byte frame; commits (or drops on err/full) in that cycle, stays IDLE.
- RECV: each valid byte written at wr_slot, offset byte_cnt; byte_cnt++.
  - valid&eof, !err → commit {wr_slot, byte_cnt+1}; wr_slot increments mod NUM_SLOTS; IDLE.
  - valid&eof, err → drop; slot reused; IDLE.
  - valid&sof (no eof) → drop current, restart frame in same slot at offset 0, stay RECV.
  - byte at offset 2^SLOT_ADDR_W (overflow) → not written, drop, DISCARD.
- DISCARD: swallow bytes until valid&eof → IDLE; valid&sof restarts as in IDLE.
- Drop: o_drop pulses, o_drop_count increments, saturates at all-ones.
- Read side: head pointer rd_slot; lengths stored per slot. i_rd_release with avail → rd_slot increments, queued decrements. Release when empty ignored.
- Commit and release in same cycle: queued unchanged, both pointers advance.
- Write slot never equals a committed, unreleased slot (ring order guaranteed by queued<NUM_SLOTS check).

## Timing
- Reset (async assert, sync deassert by integrator): FSM IDLE, pointers 0, all outputs 0. RAM contents undefined.
- Commit on eof cycle N → o_rd_frame_avail/o_frames_queued updated cycle N+1.
- o_rd_data valid one cycle after i_rd_addr; reading slot being written returns undefined data, not a fault.
- Release at cycle N → next descriptor visible cycle N+1.
- Full check uses registered o_frames_queued plus same-cycle release (release frees slot for same-cycle sof).
- o_drop asserted in the cycle after the dropping beat; counter updated same cycle as pulse.
- Reset mid-frame: partial frame lost, no drop counted.

## Structure
- Shared package eth_pkg: write FSM state enum, default parameter constants, clog2-derived width localparams.
- One sub-module: eth_frame_ram, simple dual-port RAM, NUM_SLOTS·2^SLOT_ADDR_W × DATA_W, write port by FSM, registered read port by {rd_slot, i_rd_addr}.
- Length store: NUM_SLOTS × LEN_W register array in top.

## Test plan
- Reset, three good frames of 64, 1, 1500 bytes → queued=3, head len 64/1/1500 in order after releases, data matches byte-for-byte.
- Fill 4 slots, send fifth 100-byte frame → dropped, o_drop one pulse, drop_count=1, queued=4; release one then resend → accepted.
- 60-byte frame with i_wr_err on eof → no commit, drop_count+1, next good frame lands in same slot index.
- 2100-byte frame with SLOT_ADDR_W=11 → dropped at byte 2048, DISCARD until eof, no slot corruption of neighbouring slots.
- sof mid-frame at byte 30 then 40 more bytes + eof → length 40 committed, drop_count+1.
- Commit and release in same cycle with queued=4 and sof same cycle → frame accepted, queued stays 4; assert i_rst_n mid-frame → all outputs 0 next edge.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet RX frame queue.
//   wr_state_e   : write-side FSM state encoding
//   DEF_*        : default parameter values for the queue and its RAM
//   DEF_SLOT_W   : slot index width for the default slot count
//   DEF_QCNT_W   : queued-frame counter width for the default slot count
package eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DISCARD = 2'd2
  } wr_state_e;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_NUM_SLOTS   = 4;
  localparam int DEF_SLOT_ADDR_W = 11;
  localparam int DEF_LEN_W       = 16;
  localparam int DEF_CNT_W       = 16;

  localparam int DEF_SLOT_W = $clog2(DEF_NUM_SLOTS);
  localparam int DEF_QCNT_W = $clog2(DEF_NUM_SLOTS + 1);

endpackage

// File: rtl/eth_frame_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
//   clk, rst_n      : clock, async active-low reset (read register only)
//   we/waddr/wdata  : write port
//   raddr/rdata     : read port, rdata valid one cycle after raddr
module eth_frame_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Storage itself is left unreset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/eth_rx_frame_queue.sv
// Multi-slot RX frame buffer between the RX byte stream and the consumer.
// Good frames are committed in order with their length; bad, truncated,
// restarted or oversize frames are dropped without consuming a slot.
//   i_main_clk, i_rst_n           : clock, async active-low reset
//   i_wr_*                        : byte stream from the RX FSM
//   o_rd_frame_avail/slot/len     : head descriptor
//   i_rd_addr, o_rd_data          : head-slot byte read, one-cycle latency
//   i_rd_release                  : pop head frame
//   o_frames_queued               : committed frames held
//   o_drop, o_drop_count          : drop pulse and saturating drop counter
//   o_busy                        : write FSM not idle
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_IDLE    | waiting for a start-of-frame beat
// ST_RECV    | storing bytes of the current frame into wr_slot
// ST_DISCARD | swallowing the rest of a dropped frame until eof
module eth_rx_frame_queue
  import eth_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_SLOTS   = DEF_NUM_SLOTS,
  parameter int SLOT_ADDR_W = DEF_SLOT_ADDR_W,
  parameter int LEN_W       = DEF_LEN_W,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                             i_main_clk,
  input  logic                             i_rst_n,
  input  logic                             i_wr_valid,
  input  logic [DATA_W-1:0]                i_wr_data,
  input  logic                             i_wr_sof,
  input  logic                             i_wr_eof,
  input  logic                             i_wr_err,
  output logic                             o_rd_frame_avail,
  output logic [$clog2(NUM_SLOTS)-1:0]     o_rd_slot,
  output logic [LEN_W-1:0]                 o_rd_frame_len,
  input  logic [SLOT_ADDR_W-1:0]           i_rd_addr,
  output logic [DATA_W-1:0]                o_rd_data,
  input  logic                             i_rd_release,
  output logic [$clog2(NUM_SLOTS+1)-1:0]   o_frames_queued,
  output logic [CNT_W-1:0]                 o_drop_count,
  output logic                             o_drop,
  output logic                             o_busy
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int QCNT_W = $clog2(NUM_SLOTS + 1);
  localparam int BCNT_W = SLOT_ADDR_W + 1;

  wr_state_e         state, state_nxt, st_state;
  logic [BCNT_W-1:0] byte_cnt, byte_cnt_nxt;
  logic [SLOT_W-1:0] wr_slot, rd_slot;
  logic [QCNT_W-1:0] queued;
  logic [LEN_W-1:0]  len_mem [NUM_SLOTS];
  logic [CNT_W-1:0]  drop_cnt, drop_sat;
  logic [CNT_W:0]    drop_sum;
  logic              drop_q;

  logic                   rel_fire, full, sof_beat;
  logic                   st_we, st_commit, st_drop;
  logic                   ram_we, commit;
  logic [SLOT_ADDR_W-1:0] ram_off;
  logic [1:0]             drop_inc;
  logic [LEN_W-1:0]       commit_len;

  // A same-cycle release frees a slot for a same-cycle sof.
  assign rel_fire = i_rd_release && (queued != '0);
  assign full     = (queued == QCNT_W'(NUM_SLOTS)) && !rel_fire;
  assign sof_beat = i_wr_valid && i_wr_sof;

  // Outcome of a sof beat, shared by every state that can start a frame.
  always_comb begin
    st_we     = 1'b0;
    st_commit = 1'b0;
    st_drop   = 1'b0;
    st_state  = ST_IDLE;
    if (full) begin
      st_drop  = 1'b1;
      st_state = i_wr_eof ? ST_IDLE : ST_DISCARD;
    end else begin
      st_we = 1'b1;
      if (!i_wr_eof)     st_state  = ST_RECV;
      else if (i_wr_err) st_drop   = 1'b1;
      else               st_commit = 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    ram_we       = 1'b0;
    ram_off      = '0;
    commit       = 1'b0;
    drop_inc     = 2'd0;
    commit_len   = LEN_W'(1);
    case (state)
      ST_IDLE: begin
        if (sof_beat) begin
          ram_we       = st_we;
          commit       = st_commit;
          drop_inc     = {1'b0, st_drop};
          state_nxt    = st_state;
          byte_cnt_nxt = BCNT_W'(1);
        end
      end
      ST_RECV: begin
        if (i_wr_valid) begin
          if (i_wr_sof) begin
            // Restart in the same slot; the interrupted frame is a drop.
            ram_we       = st_we;
            commit       = st_commit;
            drop_inc     = 2'd1 + {1'b0, st_drop};
            state_nxt    = st_state;
            byte_cnt_nxt = BCNT_W'(1);
          end else if (byte_cnt[SLOT_ADDR_W]) begin
            // Slot is full: this byte would spill into the next slot.
            drop_inc  = 2'd1;
            state_nxt = i_wr_eof ? ST_IDLE : ST_DISCARD;
          end else begin
            ram_we       = 1'b1;
            ram_off      = byte_cnt[SLOT_ADDR_W-1:0];
            byte_cnt_nxt = byte_cnt + BCNT_W'(1);
            if (i_wr_eof) begin
              state_nxt = ST_IDLE;
              if (i_wr_err) begin
                drop_inc = 2'd1;
              end else begin
                commit     = 1'b1;
                commit_len = LEN_W'(byte_cnt) + LEN_W'(1);
              end
            end
          end
        end
      end
      ST_DISCARD: begin
        if (sof_beat) begin
          ram_we       = st_we;
          commit       = st_commit;
          drop_inc     = {1'b0, st_drop};
          state_nxt    = st_state;
          byte_cnt_nxt = BCNT_W'(1);
        end else if (i_wr_valid && i_wr_eof) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(drop_inc);
    drop_sat = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge i_main_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      byte_cnt <= '0;
      wr_slot  <= '0;
      rd_slot  <= '0;
      queued   <= '0;
      drop_cnt <= '0;
      drop_q   <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) len_mem[i] <= '0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      drop_q   <= (drop_inc != 2'd0);
      drop_cnt <= drop_sat;
      if (commit) begin
        len_mem[wr_slot] <= commit_len;
        wr_slot          <= wr_slot + SLOT_W'(1);
      end
      if (rel_fire) rd_slot <= rd_slot + SLOT_W'(1);
      case ({commit, rel_fire})
        2'b10:   queued <= queued + QCNT_W'(1);
        2'b01:   queued <= queued - QCNT_W'(1);
        default: queued <= queued;
      endcase
    end
  end

  eth_frame_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (SLOT_W + SLOT_ADDR_W)
  ) u_ram (
    .clk   (i_main_clk),
    .rst_n (i_rst_n),
    .we    (ram_we),
    .waddr ({wr_slot, ram_off}),
    .wdata (i_wr_data),
    .raddr ({rd_slot, i_rd_addr}),
    .rdata (o_rd_data)
  );

  assign o_rd_frame_avail = (queued != '0);
  assign o_rd_slot        = rd_slot;
  assign o_rd_frame_len   = len_mem[rd_slot];
  assign o_frames_queued  = queued;
  assign o_drop_count     = drop_cnt;
  assign o_drop           = drop_q;
  assign o_busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_eth_rx_frame_queue.sv
// Self-checking bench for eth_rx_frame_queue with default parameters.
// A frame-level model (queue of committed frames, drop tally) predicts
// every descriptor, data byte and counter value.
module tb_eth_rx_frame_queue;
  import eth_pkg::*;

  localparam int NS         = DEF_NUM_SLOTS;
  localparam int SAW        = DEF_SLOT_ADDR_W;
  localparam int SLOT_BYTES = 1 << SAW;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    wr_valid = 1'b0, wr_sof = 1'b0, wr_eof = 1'b0, wr_err = 1'b0;
  logic [DEF_DATA_W-1:0]   wr_data = '0;
  logic [SAW-1:0]          rd_addr = '0;
  logic                    rd_release = 1'b0;
  logic                    o_rd_frame_avail, o_drop, o_busy;
  logic [DEF_SLOT_W-1:0]   o_rd_slot;
  logic [DEF_LEN_W-1:0]    o_rd_frame_len;
  logic [DEF_DATA_W-1:0]   o_rd_data;
  logic [DEF_QCNT_W-1:0]   o_frames_queued;
  logic [DEF_CNT_W-1:0]    o_drop_count;

  always #5 clk = ~clk;

  eth_rx_frame_queue dut (
    .i_main_clk       (clk),
    .i_rst_n          (rst_n),
    .i_wr_valid       (wr_valid),
    .i_wr_data        (wr_data),
    .i_wr_sof         (wr_sof),
    .i_wr_eof         (wr_eof),
    .i_wr_err         (wr_err),
    .o_rd_frame_avail (o_rd_frame_avail),
    .o_rd_slot        (o_rd_slot),
    .o_rd_frame_len   (o_rd_frame_len),
    .i_rd_addr        (rd_addr),
    .o_rd_data        (o_rd_data),
    .i_rd_release     (rd_release),
    .o_frames_queued  (o_frames_queued),
    .o_drop_count     (o_drop_count),
    .o_drop           (o_drop),
    .o_busy           (o_busy)
  );

  int tests = 0;
  int fails = 0;
  int drop_pulses = 0;
  int pulse_base = 0;

  always @(negedge clk) if (o_drop === 1'b1) drop_pulses++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Reference model: committed frames in order, total drops, commit count.
  typedef struct { int len; int slot; int seed; } frame_t;
  frame_t mq[$];
  int     m_drops = 0;
  int     m_commits = 0;

  function automatic logic [7:0] gen(input int seed, input int k);
    return 8'(seed * 37 + k * 13 + (k >> 5) + (seed >> 2));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_beats(input int seed, input int n, input bit sof, input bit eof,
                            input bit err, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 7) == 0) begin
        wr_valid = 1'b0;
        tick();
      end
      wr_valid = 1'b1;
      wr_data  = gen(seed, k);
      wr_sof   = sof && (k == 0);
      wr_eof   = eof && (k == n - 1);
      wr_err   = wr_eof ? err : 1'($urandom_range(0, 1));
      tick();
    end
    wr_valid = 1'b0;
    wr_sof   = 1'b0;
    wr_eof   = 1'b0;
    wr_err   = 1'b0;
  endtask

  // Whole frame; the model decides commit versus drop from the frame-level rules.
  task automatic send_frame(input int seed, input int len, input bit err, input bit gaps);
    frame_t f;
    send_beats(seed, len, 1'b1, 1'b1, err, gaps);
    tick();
    if (mq.size() == NS || err || len > SLOT_BYTES) begin
      m_drops++;
    end else begin
      f.len = len; f.slot = m_commits % NS; f.seed = seed;
      mq.push_back(f);
      m_commits++;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, " queued"}, 64'(o_frames_queued), 64'(mq.size()));
    check({tag, " avail"}, 64'(o_rd_frame_avail), 64'(mq.size() != 0));
    check({tag, " drop_count"}, 64'(o_drop_count), 64'(m_drops));
    check({tag, " drop_pulses"}, 64'(drop_pulses - pulse_base), 64'(m_drops));
    check({tag, " busy"}, 64'(o_busy), 64'd0);
  endtask

  task automatic check_head(input string tag);
    frame_t f;
    int     mism;
    int     first_bad;
    logic [7:0] first_got;
    f = mq[0];
    mism = 0;
    first_bad = -1;
    first_got = '0;
    check({tag, " head avail"}, 64'(o_rd_frame_avail), 64'd1);
    check({tag, " head len"}, 64'(o_rd_frame_len), 64'(f.len));
    check({tag, " head slot"}, 64'(o_rd_slot), 64'(f.slot));
    for (int k = 0; k < f.len; k++) begin
      rd_addr = SAW'(k);
      tick();
      if (o_rd_data !== gen(f.seed, k)) begin
        if (mism == 0) begin first_bad = k; first_got = o_rd_data; end
        mism++;
      end
    end
    if (mism != 0)
      $display("  first bad byte at offset %0d: got %0h want %0h", first_bad, first_got,
               gen(f.seed, first_bad));
    check({tag, " head data mismatches"}, 64'(mism), 64'd0);
  endtask

  task automatic check_and_release(input string tag);
    check_head(tag);
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
    void'(mq.pop_front());
  endtask

  typedef struct {
    int n_rel;
    int len;
    bit err;
    int exp_q;
    int exp_drops;
  } vec_t;

  vec_t vt[10];

  initial begin
    frame_t nf;
    vt[0] = '{0,   64, 1'b0, 1, 0};
    vt[1] = '{0,    1, 1'b0, 2, 0};
    vt[2] = '{0, 1500, 1'b0, 3, 0};
    vt[3] = '{0,   60, 1'b1, 3, 1};
    vt[4] = '{0,   10, 1'b0, 4, 1};
    vt[5] = '{0,  100, 1'b0, 4, 2};
    vt[6] = '{1,  100, 1'b0, 4, 2};
    vt[7] = '{3, 2100, 1'b0, 1, 3};
    vt[8] = '{0, 2048, 1'b0, 2, 3};
    vt[9] = '{2,    5, 1'b1, 0, 4};

    #2 rst_n = 1'b0;
    tick(); tick();
    check("rst avail", 64'(o_rd_frame_avail), 64'd0);
    check("rst slot", 64'(o_rd_slot), 64'd0);
    check("rst len", 64'(o_rd_frame_len), 64'd0);
    check("rst data", 64'(o_rd_data), 64'd0);
    check("rst queued", 64'(o_frames_queued), 64'd0);
    check("rst drop_count", 64'(o_drop_count), 64'd0);
    check("rst drop", 64'(o_drop), 64'd0);
    check("rst busy", 64'(o_busy), 64'd0);
    rst_n = 1'b1;
    tick();
    pulse_base = drop_pulses;

    for (int i = 0; i < 10; i++) begin
      for (int r = 0; r < vt[i].n_rel; r++) check_and_release($sformatf("vec%0d rel%0d", i, r));
      send_frame(100 + i, vt[i].len, vt[i].err, 1'b0);
      check($sformatf("vec%0d queued", i), 64'(o_frames_queued), 64'(vt[i].exp_q));
      check($sformatf("vec%0d drop_count", i), 64'(o_drop_count), 64'(vt[i].exp_drops));
      check_state($sformatf("vec%0d", i));
    end

    // sof arrives 30 bytes into a frame: old frame dropped, new 40-byte frame kept.
    send_beats(200, 30, 1'b1, 1'b0, 1'b0, 1'b0);
    send_beats(201, 40, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    m_drops++;
    nf.len = 40; nf.slot = m_commits % NS; nf.seed = 201;
    mq.push_back(nf);
    m_commits++;
    check("restart drop_count", 64'(o_drop_count), 64'(m_drops));
    check_state("restart");
    check_and_release("restart");

    // Full queue: release plus a 1-byte frame in the same cycle is accepted.
    for (int i = 0; i < NS; i++) send_frame(300 + i, 20 + i, 1'b0, 1'b0);
    check_state("fill");
    check_head("concurrent");
    wr_valid = 1'b1; wr_sof = 1'b1; wr_eof = 1'b1; wr_err = 1'b0; wr_data = gen(310, 0);
    rd_release = 1'b1;
    tick();
    wr_valid = 1'b0; wr_sof = 1'b0; wr_eof = 1'b0; rd_release = 1'b0;
    tick();
    void'(mq.pop_front());
    nf.len = 1; nf.slot = m_commits % NS; nf.seed = 310;
    mq.push_back(nf);
    m_commits++;
    check("concurrent queued", 64'(o_frames_queued), 64'd4);
    check_state("concurrent");
    while (mq.size() > 0) check_and_release("concurrent drain");

    // Reset in the middle of a frame.
    send_frame(390, 12, 1'b0, 1'b0);
    send_beats(400, 25, 1'b1, 1'b0, 1'b0, 1'b0);
    check("midframe busy", 64'(o_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst avail", 64'(o_rd_frame_avail), 64'd0);
    check("midrst slot", 64'(o_rd_slot), 64'd0);
    check("midrst len", 64'(o_rd_frame_len), 64'd0);
    check("midrst data", 64'(o_rd_data), 64'd0);
    check("midrst queued", 64'(o_frames_queued), 64'd0);
    check("midrst drop_count", 64'(o_drop_count), 64'd0);
    check("midrst drop", 64'(o_drop), 64'd0);
    check("midrst busy", 64'(o_busy), 64'd0);
    mq.delete();
    m_drops = 0;
    m_commits = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    pulse_base = drop_pulses;

    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
    check("empty release queued", 64'(o_frames_queued), 64'd0);
    check("empty release slot", 64'(o_rd_slot), 64'd0);
    check_state("post reset");

    // Randomized traffic against the model.
    for (int it = 0; it < 60; it++) begin
      int len;
      bit err;
      if ($urandom_range(0, 9) < 3 && mq.size() > 0) begin
        check_and_release($sformatf("rand%0d", it));
      end else begin
        len = ($urandom_range(0, 14) == 0) ? int'($urandom_range(2040, 2100))
                                           : int'($urandom_range(1, 120));
        err = ($urandom_range(0, 5) == 0);
        send_frame(500 + it, len, err, 1'b1);
      end
      check_state($sformatf("rand%0d", it));
    end
    while (mq.size() > 0) check_and_release("final drain");
    check_state("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
